// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory responders: the handshake state
// encoding, the word size and the address legality check. The data-port
// responder uses it today; the instruction-fetch responder will reuse it.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } memStateT;

   localparam int unsigned WORD_BYTES = 4;

   // An access is legal when it is word aligned and lands inside a RAM of
   // 'depth' words. Anything else is answered with Error and no side effect.
   function automatic logic addrOk(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && (addr < depth * WORD_BYTES);
   endfunction

endpackage

// File: rtl/dmem_ram_core.sv
// Synchronous single-port word RAM backing the data responder. One access per
// enabled cycle: a write stores wdata, otherwise the addressed word is
// registered onto rdata. Contents are deliberately not reset.
module dmem_ram_core #(
   parameter int DEPTH     = 256,
   parameter int ADDR_BITS = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 en,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [DEPTH];

   // Single access port: a write and a read never happen in the same cycle,
   // so rdata keeps the last read word while writes are committed.
   always_ff @(posedge clock) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder at the target end of the CPU data port. A request is
// accepted in IDLE, held for WAIT_CYCLES wait states, then answered with a
// single-cycle Ready pulse. Busy covers the whole transaction so the pipeline
// can stall on it. Misaligned or out-of-range accesses are answered with Error,
// zero read data and no write.
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        Req,
   input  logic        WriteEnable,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Error,
   output logic        Busy
);

   localparam int         ADDR_BITS  = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_CYCLES);

   memStateT             state;
   memStateT             nextState;
   logic [3:0]           waitCount;
   logic                 weLatched;
   logic                 okLatched;
   logic [ADDR_BITS-1:0] indexLatched;
   logic [31:0]          dataLatched;
   logic [31:0]          holdData;
   logic                 liveOk;
   logic                 accept;
   logic                 commit;
   logic                 respShown;
   logic                 ramWe;
   logic [ADDR_BITS-1:0] ramAddr;
   logic [31:0]          ramWdata;
   logic [31:0]          ramRdata;

   // Handshake sequencing. With no wait states an accepted request goes
   // straight to RESP; otherwise it sits in WAIT until the counter reaches the
   // configured number of wait states. RESP always lasts one cycle, which is
   // what keeps Ready from ever being high on two consecutive cycles.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (Req) begin
               nextState = (WAIT_LIMIT == 4'd0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (waitCount == WAIT_LIMIT) begin
               nextState = RESP;
            end
         end
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // The RAM is accessed on the edge that enters RESP. For zero wait states
   // that is the acceptance edge itself, when the latches are still loading,
   // so the live request fields are steered to the RAM while in IDLE. Illegal
   // writes are suppressed here, which is how they get dropped.
   always_comb begin
      liveOk    = addrOk(Address, DEPTH);
      accept    = (state == IDLE) && Req;
      commit    = (nextState == RESP);
      ramWe     = 1'b0;
      ramAddr   = indexLatched;
      ramWdata  = dataLatched;
      if (state == IDLE) begin
         ramWe    = commit && WriteEnable && liveOk;
         ramAddr  = Address[ADDR_BITS+1:2];
         ramWdata = WriteData;
      end else begin
         ramWe = commit && weLatched && okLatched;
      end
   end

   // Response signalling. The response word is shown during RESP for reads
   // and for any rejected access (forced to zero); otherwise ReadData keeps
   // showing the last word that was presented.
   always_comb begin
      Ready     = (state == RESP);
      Error     = Ready && !okLatched;
      Busy      = (state != IDLE);
      respShown = Ready && (!weLatched || !okLatched);
      ReadData  = holdData;
      if (respShown) begin
         ReadData = okLatched ? ramRdata : 32'h0;
      end
   end

   // State register. Reset drops any transaction in flight; a pending write
   // is lost because it only reaches the RAM on the RESP entry edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Wait-state counter: starts at one on the first WAIT cycle and counts up
   // while waiting, so the WAIT phase lasts exactly WAIT_CYCLES cycles.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         waitCount <= 4'd0;
      end else if (nextState == WAIT) begin
         waitCount <= (state == WAIT) ? waitCount + 4'd1 : 4'd1;
      end else begin
         waitCount <= 4'd0;
      end
   end

   // Request capture on acceptance. These fields stay frozen until the next
   // acceptance, so Req or Address changing mid-transaction has no effect.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         weLatched    <= 1'b0;
         okLatched    <= 1'b0;
         indexLatched <= '0;
         dataLatched  <= 32'h0;
      end else if (accept) begin
         weLatched    <= WriteEnable;
         okLatched    <= liveOk;
         indexLatched <= Address[ADDR_BITS+1:2];
         dataLatched  <= WriteData;
      end
   end

   // Remember whatever response word was presented so ReadData stays stable
   // between completions instead of following the RAM output register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         holdData <= 32'h0;
      end else if (respShown) begin
         holdData <= ReadData;
      end
   end

   dmem_ram_core #(
      .DEPTH(DEPTH)
   ) ramCore (
      .clock(clock),
      .en   (commit),
      .we   (ramWe),
      .addr (ramAddr),
      .wdata(ramWdata),
      .rdata(ramRdata)
   );

endmodule
